datapath_seq: RTL

//   Parametrised, self-sequencing successor of the CPU datapath: register file, B-operand shifter, ALU,
//   A/B/C pipeline registers and a Z/N/V status register, driven by an internal FSM instead of raw load strobes.

---
 rtl/datapath_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/datapath_seq.sv
// Self-sequencing register-file/shifter/ALU datapath driven by a valid/ready command port.
// Latency: ALU op writes back and pulses done 4 cycles after accept; load-immediate 1 cycle.
// Backpressure: cmd_ready is high only in IDLE; commands presented while busy are dropped, not queued.
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_load,
  input  logic [1:0]                 cmd_aluop,
  input  logic [1:0]                 cmd_shift,
  input  logic                       cmd_asel,
  input  logic                       cmd_bsel,
  input  logic [$clog2(NREGS)-1:0]   cmd_rn,
  input  logic [$clog2(NREGS)-1:0]   cmd_rm,
  input  logic [$clog2(NREGS)-1:0]   cmd_rd,
  input  logic [WIDTH-1:0]           cmd_imm,
  output logic                       done,
  output logic [WIDTH-1:0]           datapath_out,
  output logic                       Z_out,
  output logic                       N_out,
  output logic                       V_out,
  input  logic [$clog2(NREGS)-1:0]   dbg_addr,
  output logic [WIDTH-1:0]           dbg_data
);

  localparam int AW  = $clog2(NREGS);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_EXE,
    S_WB,
    S_LDI
  } state_t;

  typedef struct packed {
    logic             load;
    logic [1:0]       aluop;
    logic [1:0]       shift;
    logic             asel;
    logic             bsel;
    logic [AW-1:0]    rn;
    logic [AW-1:0]    rm;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] imm;
  } cmd_t;

  state_t           state;
  state_t           state_nxt;
  cmd_t             cmd_q;
  cmd_t             cmd_in;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic             z_q;
  logic             n_q;
  logic             v_q;

  logic             accept;
  logic             a_en;
  logic             b_en;
  logic             c_en;
  logic             wb_en;
  logic             ldi_en;
  logic             done_set;

  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bsh;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;

  assign cmd_in = '{
    load:  cmd_load,
    aluop: cmd_aluop,
    shift: cmd_shift,
    asel:  cmd_asel,
    bsel:  cmd_bsel,
    rn:    cmd_rn,
    rm:    cmd_rm,
    rd:    cmd_rd,
    imm:   cmd_imm
  };

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = cmd_load ? S_LDI : S_RDA;
        end
      end
      S_RDA:   state_nxt = S_RDB;
      S_RDB:   state_nxt = S_EXE;
      S_EXE:   state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      S_LDI:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state strobes into the datapath
  always_comb begin
    cmd_ready = 1'b0;
    a_en      = 1'b0;
    b_en      = 1'b0;
    c_en      = 1'b0;
    wb_en     = 1'b0;
    ldi_en    = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_RDA:   a_en      = 1'b1;
      S_RDB:   b_en      = 1'b1;
      S_EXE:   c_en      = 1'b1;
      S_WB:    wb_en     = 1'b1;
      S_LDI:   ldi_en    = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  assign accept   = cmd_valid & cmd_ready;
  assign done_set = wb_en | ldi_en;

  // Shifter on B, then ALU; overflow judged against the shifted B sign.
  always_comb begin
    bsh = b_q;
    case (cmd_q.shift)
      2'b01:   bsh = {b_q[MSB-1:0], 1'b0};
      2'b10:   bsh = {1'b0, b_q[MSB:1]};
      2'b11:   bsh = {b_q[MSB], b_q[MSB:1]};
      default: bsh = b_q;
    endcase
    ain   = cmd_q.asel ? '0 : a_q;
    alu_r = '0;
    alu_v = 1'b0;
    case (cmd_q.aluop)
      2'b00: begin
        alu_r = ain + bsh;
        alu_v = (ain[MSB] == bsh[MSB]) && (alu_r[MSB] != ain[MSB]);
      end
      2'b01: begin
        alu_r = ain - bsh;
        alu_v = (ain[MSB] != bsh[MSB]) && (alu_r[MSB] != ain[MSB]);
      end
      2'b10:   alu_r = ain & bsh;
      default: alu_r = ~bsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= done_set;
      if (accept) begin
        cmd_q <= cmd_in;
      end
      if (a_en) begin
        a_q <= regs[cmd_q.rn];
      end
      if (b_en) begin
        b_q <= cmd_q.bsel ? cmd_q.imm : regs[cmd_q.rm];
      end
      if (c_en) begin
        c_q <= alu_r;
        z_q <= (alu_r == '0);
        n_q <= alu_r[MSB];
        v_q <= alu_v;
      end
      if (wb_en) begin
        regs[cmd_q.rd] <= c_q;
      end
      if (ldi_en) begin
        regs[cmd_q.rd] <= cmd_q.imm;
      end
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;
  assign dbg_data     = regs[dbg_addr];

endmodule
